// File: rtl/dpram_xfer_ctrl.sv
// Block-op sequencer for a dual-port RAM with 1-cycle registered read:
// COPY streams port A reads into port B writes, FILL writes a constant pair per clock.
module dpram_xfer_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_done,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] din_a,
  input  logic [DATA_WIDTH-1:0] dout_a,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] din_b
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_ERR,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW:0]   len_q, len_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   words_q, words_d;
  logic          err_q, err_d;
  logic          cwr_q, cwr_d;
  logic          we_a_q, we_a_d;
  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [DW-1:0] din_a_q, din_a_d;
  logic          we_b_q, we_b_d;
  logic [AW-1:0] addr_b_q, addr_b_d;
  logic [DW-1:0] din_b_q, din_b_d;

  logic [AW-1:0] diff_ds, diff_sd;
  logic          overlap;
  logic [AW+1:0] two_idx, remain;

  assign diff_ds = dst_addr - src_addr;
  assign diff_sd = src_addr - dst_addr;
  assign overlap = ({1'b0, diff_ds} < len) || ({1'b0, diff_sd} < len);
  assign two_idx = {idx_q, 1'b0};
  assign remain  = {1'b0, len_q} - two_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      idx_q    <= '0;
      words_q  <= '0;
      err_q    <= 1'b0;
      cwr_q    <= 1'b0;
      we_a_q   <= 1'b0;
      addr_a_q <= '0;
      din_a_q  <= '0;
      we_b_q   <= 1'b0;
      addr_b_q <= '0;
      din_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      idx_q    <= idx_d;
      words_q  <= words_d;
      err_q    <= err_d;
      cwr_q    <= cwr_d;
      we_a_q   <= we_a_d;
      addr_a_q <= addr_a_d;
      din_a_q  <= din_a_d;
      we_b_q   <= we_b_d;
      addr_b_q <= addr_b_d;
      din_b_q  <= din_b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    fill_d   = fill_q;
    idx_d    = idx_q;
    err_d    = err_q;
    words_d  = words_q + (AW+1)'(we_a_q) + (AW+1)'(we_b_q);
    cwr_d    = 1'b0;
    we_a_d   = 1'b0;
    addr_a_d = addr_a_q;
    din_a_d  = din_a_q;
    we_b_d   = 1'b0;
    addr_b_d = addr_b_q;
    din_b_d  = cwr_q ? dout_a : din_b_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          fill_d  = fill_data;
          idx_d   = (AW+1)'(1);
          words_d = '0;
          err_d   = 1'b0;
          // len=0 shares the no-work path through S_ERR, just without err
          if ((len > DEPTH) || (!mode && (len != '0) && overlap)) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else if (len == '0) begin
            state_d = S_ERR;
          end else begin
            state_d = S_RUN;
            if (mode) begin
              we_a_d   = 1'b1;
              addr_a_d = dst_addr;
              din_a_d  = fill_data;
              if (len > (AW+1)'(1)) begin
                we_b_d   = 1'b1;
                addr_b_d = dst_addr + AW'(1);
                din_b_d  = fill_data;
              end
            end else begin
              addr_a_d = src_addr;
            end
          end
        end
      end

      S_RUN: begin
        if (!mode_q) begin
          // write next clock carries the read issued this clock
          we_b_d   = 1'b1;
          cwr_d    = 1'b1;
          addr_b_d = dst_q + idx_q[AW-1:0] - AW'(1);
          if (idx_q == len_q) begin
            state_d = S_DRAIN;
          end else begin
            addr_a_d = src_q + idx_q[AW-1:0];
            idx_d    = idx_q + (AW+1)'(1);
          end
        end else begin
          if (two_idx >= {1'b0, len_q}) begin
            state_d = S_DONE;
          end else begin
            we_a_d   = 1'b1;
            addr_a_d = dst_q + two_idx[AW-1:0];
            din_a_d  = fill_q;
            idx_d    = idx_q + (AW+1)'(1);
            if (remain > (AW+2)'(1)) begin
              we_b_d   = 1'b1;
              addr_b_d = dst_q + two_idx[AW-1:0] + AW'(1);
              din_b_d  = fill_q;
            end
          end
        end
      end

      S_DRAIN: state_d = S_DONE;
      S_ERR:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_DONE) && err_q;
  assign words_done = words_q;
  assign we_a       = we_a_q;
  assign addr_a     = addr_a_q;
  assign din_a      = din_a_q;
  assign we_b       = we_b_q;
  assign addr_b     = addr_b_q;
  assign din_b      = cwr_q ? dout_a : din_b_q;

endmodule

// File: tb/tb_dpram_xfer_ctrl.sv
// Scoreboard bench for dpram_xfer_ctrl with a behavioural dual-port RAM.
module tb_dpram_xfer_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  typedef struct {
    logic        err;
    int unsigned words;
    int unsigned busy;
  } exp_t;

  typedef logic [DW-1:0] vec8_t [8];

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   len;
  logic [DW-1:0] fill_data;
  logic          busy, done, err;
  logic [AW:0]   words_done;
  logic          we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b, dout_a;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] mem [16];

  int   checks = 0;
  int   fails  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dpram_xfer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
    .busy(busy), .done(done), .err(err), .words_done(words_done),
    .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
    .we_b(we_b), .addr_b(addr_b), .din_b(din_b)
  );

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else begin
      dout_a <= mem[addr_a];
      if (we_a) mem[addr_a] <= din_a;
      if (we_b) mem[addr_b] <= din_b;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: counts busy clocks and writes per op, checks them on each done pulse.
  int unsigned mon_busy = 0;
  int unsigned mon_wr   = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_busy = 0;
      mon_wr   = 0;
    end else begin
      if (busy) mon_busy++;
      mon_wr += int'(we_a) + int'(we_b);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          e = exp_q.pop_front();
          chk("sb_err", 64'(err), 64'(e.err));
          chk("sb_words_done", 64'(words_done), 64'(e.words));
          chk("sb_writes", 64'(mon_wr), 64'(e.words));
          chk("sb_busy_clks", 64'(mon_busy), 64'(e.busy));
        end
        mon_busy = 0;
        mon_wr   = 0;
      end
    end
  end

  task automatic wait_done(input string nm, input int unsigned lat);
    int unsigned n = 0;
    bit got = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got no done in 40 clks expected done at clk %0d", nm, lat);
    end else begin
      chk({nm, "_latency"}, 64'(n), 64'(lat));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic m, input logic [AW-1:0] s,
                        input logic [AW-1:0] d, input logic [AW:0] l, input logic [DW-1:0] f,
                        input logic e_err, input int unsigned e_words,
                        input int unsigned e_busy, input int unsigned e_lat);
    exp_t e;
    e.err = e_err; e.words = e_words; e.busy = e_busy;
    exp_q.push_back(e);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = ~m; src_addr = ~s; dst_addr = ~d; fill_data = ~f;
    wait_done(nm, e_lat);
  endtask

  task automatic chk_mem(input string nm, input logic [AW-1:0] base, input int unsigned n,
                         input vec8_t v);
    for (int i = 0; i < int'(n); i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      chk($sformatf("%s_mem%0d", nm, a), 64'(mem[a]), 64'(v[i]));
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, 64'({busy, done, err, words_done}), 64'(0));
    chk({nm, "_port_a"}, 64'({we_a, addr_a, din_a}), 64'(0));
    chk({nm, "_port_b"}, 64'({we_b, addr_b, din_b}), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; fill_data = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    // RAM preload: [0..3]=11,22,33,44, others 0x10+i
    for (int i = 0; i < 16; i++) begin
      ld_en = 1'b1;
      ld_addr = AW'(i);
      case (i)
        0: ld_data = 8'h11;
        1: ld_data = 8'h22;
        2: ld_data = 8'h33;
        3: ld_data = 8'h44;
        default: ld_data = DW'(8'h10 + i);
      endcase
      @(posedge clk);
      #1;
    end
    ld_en = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("copy_basic", 1'b0, 4'd0, 4'd8, 5'd4, 8'h00, 1'b0, 4, 5, 6);
    chk_mem("copy_basic", 4'd8, 4, vec8_t'{8'h11, 8'h22, 8'h33, 8'h44, 8'h0, 8'h0, 8'h0, 8'h0});

    run_op("fill_odd", 1'b1, 4'd0, 4'd2, 5'd5, 8'hA5, 1'b0, 5, 3, 4);
    chk_mem("fill_odd", 4'd2, 6, vec8_t'{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h17, 8'h0, 8'h0});

    run_op("copy_wrap", 1'b0, 4'd14, 4'd4, 5'd4, 8'h00, 1'b0, 4, 5, 6);
    chk_mem("copy_wrap", 4'd4, 4, vec8_t'{8'h1E, 8'h1F, 8'h11, 8'h22, 8'h0, 8'h0, 8'h0, 8'h0});

    run_op("copy_overlap", 1'b0, 4'd0, 4'd2, 5'd4, 8'h00, 1'b1, 0, 0, 2);
    chk_mem("copy_overlap", 4'd0, 4, vec8_t'{8'h11, 8'h22, 8'hA5, 8'hA5, 8'h0, 8'h0, 8'h0, 8'h0});

    run_op("len_zero", 1'b0, 4'd0, 4'd8, 5'd0, 8'h00, 1'b0, 0, 0, 2);
    run_op("len_17", 1'b1, 4'd0, 4'd0, 5'd17, 8'hEE, 1'b1, 0, 0, 2);
    chk_mem("len_17", 4'd0, 2, vec8_t'{8'h11, 8'h22, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});

    run_op("fill_even", 1'b1, 4'd0, 4'd12, 5'd2, 8'h5A, 1'b0, 2, 1, 2);
    chk_mem("fill_even", 4'd12, 3, vec8_t'{8'h5A, 8'h5A, 8'h1E, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});

    // Abort a COPY len=8 with reset during its second write clock
    mode = 1'b0; src_addr = 4'd0; dst_addr = 4'd8; len = 5'd8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("abort_in_write", 64'(we_b), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'({done, busy, we_a, we_b}), 64'(0));
    end
    @(posedge clk);
    #1;

    // Full COPY len=8; a FILL start pulse mid-op must be ignored
    begin
      exp_t e;
      e.err = 1'b0; e.words = 8; e.busy = 9;
      exp_q.push_back(e);
    end
    mode = 1'b0; src_addr = 4'd0; dst_addr = 4'd8; len = 5'd8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    mode = 1'b1; dst_addr = 4'd0; len = 5'd3; fill_data = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("copy_after_rst", 8);
    chk_mem("copy_after_rst", 4'd8, 8,
            vec8_t'{8'h11, 8'h22, 8'hA5, 8'hA5, 8'h1E, 8'h1F, 8'h11, 8'h22});
    chk_mem("ignored_start", 4'd0, 3, vec8_t'{8'h11, 8'h22, 8'hA5, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0});

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    chk("idle_after_all", 64'({busy, done}), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
